// File: rtl/traffic_vehicle_counter.sv
// Four-approach vehicle queue counter: synchronises and debounces raw arrival sensors,
// counts one vehicle per accepted rising level and removes one per departure strobe.
module traffic_vehicle_counter #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int CNT_W           = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       sens_ns,
    input  logic       sens_sn,
    input  logic       sens_ew,
    input  logic       sens_we,
    input  logic [3:0] dep_4b,
    output logic [3:0] count_ns_4b,
    output logic [3:0] count_sn_4b,
    output logic [3:0] count_ew_4b,
    output logic [3:0] count_we_4b,
    output logic [3:0] ovf_4b
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [3:0] sensRaw;
    logic [3:0] countArr [4];

    assign sensRaw = {sens_we, sens_ew, sens_sn, sens_ns};

    for (genvar g = 0; g < 4; g++) begin : g_chan
        logic             s1_q, s2_q;
        logic             db_q, db_d;
        logic [CNT_W-1:0] cnt_q, cnt_d;
        logic             arr;
        logic [3:0]       count_q, count_d;
        logic             ovf_q, ovf_d;

        // Debouncer: s2 must disagree with the accepted level for DEBOUNCE_CYCLES
        // consecutive cycles; only the 0->1 acceptance produces an arrival.
        always_comb begin
            db_d  = db_q;
            cnt_d = cnt_q;
            arr   = 1'b0;
            if (s2_q == db_q) begin
                cnt_d = '0;
            end else if (cnt_q == CNT_LAST) begin
                db_d  = s2_q;
                cnt_d = '0;
                arr   = s2_q;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end

        // Simultaneous arrival and departure cancel, even at the saturation limits.
        always_comb begin
            count_d = count_q;
            ovf_d   = ovf_q;
            case ({arr, dep_4b[g]})
                2'b10: begin
                    if (count_q == 4'd15) ovf_d = 1'b1;
                    else                  count_d = count_q + 4'd1;
                end
                2'b01: begin
                    if (count_q != 4'd0) count_d = count_q - 4'd1;
                end
                default: ;
            endcase
        end

        always_ff @(posedge clk) begin
            if (reset) begin
                s1_q    <= 1'b0;
                s2_q    <= 1'b0;
                db_q    <= 1'b0;
                cnt_q   <= '0;
                count_q <= 4'd0;
                ovf_q   <= 1'b0;
            end else begin
                s1_q    <= sensRaw[g];
                s2_q    <= s1_q;
                db_q    <= db_d;
                cnt_q   <= cnt_d;
                count_q <= count_d;
                ovf_q   <= ovf_d;
            end
        end

        assign countArr[g] = count_q;
        assign ovf_4b[g]   = ovf_q;
    end

    assign count_ns_4b = countArr[0];
    assign count_sn_4b = countArr[1];
    assign count_ew_4b = countArr[2];
    assign count_we_4b = countArr[3];

endmodule

// File: tb/tb_traffic_vehicle_counter.sv
// Scoreboard bench for traffic_vehicle_counter: stimulus queues hand-computed expected
// counts/flags, a negedge monitor pops and compares them against the DUT outputs.
module tb_traffic_vehicle_counter;

    typedef struct packed {
        logic [3:0] ns;
        logic [3:0] sn;
        logic [3:0] ew;
        logic [3:0] we;
        logic [3:0] ovf;
    } exp_t;

    logic       clk;
    logic       reset;
    logic [3:0] sens;
    logic [3:0] dep;
    logic [3:0] countNs, countSn, countEw, countWe, ovf;

    exp_t  expQ[$];
    string nameQ[$];
    exp_t  monExp;
    string monName;
    int    testsRun;
    int    failures;

    traffic_vehicle_counter #(
        .DEBOUNCE_CYCLES(4),
        .CNT_W(8)
    ) dut (
        .clk(clk),
        .reset(reset),
        .sens_ns(sens[0]),
        .sens_sn(sens[1]),
        .sens_ew(sens[2]),
        .sens_we(sens[3]),
        .dep_4b(dep),
        .count_ns_4b(countNs),
        .count_sn_4b(countSn),
        .count_ew_4b(countEw),
        .count_we_4b(countWe),
        .ovf_4b(ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Monitor: outputs are registered, so sample on the falling edge and drain pending expectations.
    always @(negedge clk) begin
        while (expQ.size() > 0) begin
            monExp  = expQ.pop_front();
            monName = nameQ.pop_front();
            testsRun++;
            if ({countNs, countSn, countEw, countWe, ovf} !== monExp) begin
                failures++;
                $display("[TB] FAIL %s: got ns=%0d sn=%0d ew=%0d we=%0d ovf=%b, expected ns=%0d sn=%0d ew=%0d we=%0d ovf=%b",
                         monName, countNs, countSn, countEw, countWe, ovf,
                         monExp.ns, monExp.sn, monExp.ew, monExp.we, monExp.ovf);
            end
        end
    end

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation time limit reached, got running, expected finished");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [3:0] ns, input logic [3:0] sn,
                               input logic [3:0] ew, input logic [3:0] we, input logic [3:0] fl);
        exp_t e;
        e.ns  = ns;
        e.sn  = sn;
        e.ew  = ew;
        e.we  = we;
        e.ovf = fl;
        expQ.push_back(e);
        nameQ.push_back(name);
    endtask

    task automatic applyReset();
        reset = 1'b1;
        tick(1);
        reset = 1'b0;
    endtask

    task automatic applyStimulus(input logic [3:0] mask, input int hi, input int lo);
        sens = sens | mask;
        tick(hi);
        sens = sens & ~mask;
        tick(lo);
    endtask

    initial begin
        testsRun = 0;
        failures = 0;
        reset    = 1'b1;
        sens     = 4'b0000;
        dep      = 4'b0000;
        tick(2);
        reset = 1'b0;
        checkOutput("resetState", 4'd0, 4'd0, 4'd0, 4'd0, 4'b0000);
        tick(3);
        checkOutput("idleHold", 4'd0, 4'd0, 4'd0, 4'd0, 4'b0000);

        // Test 1: held-high ns sensor counts on the 6th edge, once only
        applyReset();
        sens[0] = 1'b1;
        tick(5);
        checkOutput("nsEdge5", 4'd0, 4'd0, 4'd0, 4'd0, 4'b0000);
        tick(1);
        checkOutput("nsEdge6", 4'd1, 4'd0, 4'd0, 4'd0, 4'b0000);
        tick(4);
        checkOutput("nsHeld", 4'd1, 4'd0, 4'd0, 4'd0, 4'b0000);
        sens[0] = 1'b0;
        tick(6);

        // Test 2: short ew glitches rejected, 5-cycle pulse accepted
        applyStimulus(4'b0100, 3, 2);
        applyStimulus(4'b0100, 3, 6);
        checkOutput("ewGlitch", 4'd1, 4'd0, 4'd0, 4'd0, 4'b0000);
        applyStimulus(4'b0100, 5, 6);
        checkOutput("ewPulse5", 4'd1, 4'd0, 4'd1, 4'd0, 4'b0000);

        // Test 3: sn saturation, overflow flag, drain by strobes
        for (int i = 0; i < 15; i++) applyStimulus(4'b0010, 6, 6);
        checkOutput("sn15NoOvf", 4'd1, 4'd15, 4'd1, 4'd0, 4'b0000);
        for (int i = 0; i < 2; i++) applyStimulus(4'b0010, 6, 6);
        checkOutput("snSaturate", 4'd1, 4'd15, 4'd1, 4'd0, 4'b0010);
        for (int i = 0; i < 5; i++) begin
            dep = 4'b0010;
            tick(1);
            dep = 4'b0000;
            tick(1);
        end
        checkOutput("snDep5", 4'd1, 4'd10, 4'd1, 4'd0, 4'b0010);
        for (int i = 0; i < 11; i++) begin
            dep = 4'b0010;
            tick(1);
            dep = 4'b0000;
            tick(1);
        end
        checkOutput("snDrained", 4'd1, 4'd0, 4'd1, 4'd0, 4'b0010);
        dep = 4'b0001;
        tick(3);
        dep = 4'b0000;
        tick(1);
        checkOutput("nsUnderflow", 4'd0, 4'd0, 4'd1, 4'd0, 4'b0010);

        // Test 4: arrival coinciding with departure is a net zero
        for (int i = 0; i < 3; i++) applyStimulus(4'b1000, 6, 6);
        checkOutput("we3", 4'd0, 4'd0, 4'd1, 4'd3, 4'b0010);
        sens[3] = 1'b1;
        tick(5);
        dep = 4'b1000;
        tick(1);
        dep = 4'b0000;
        checkOutput("weCoincide3", 4'd0, 4'd0, 4'd1, 4'd3, 4'b0010);
        tick(5);
        sens[3] = 1'b0;
        tick(6);
        for (int i = 0; i < 12; i++) applyStimulus(4'b1000, 6, 6);
        checkOutput("we15", 4'd0, 4'd0, 4'd1, 4'd15, 4'b0010);
        sens[3] = 1'b1;
        tick(5);
        dep = 4'b1000;
        tick(1);
        dep = 4'b0000;
        checkOutput("weCoincide15", 4'd0, 4'd0, 4'd1, 4'd15, 4'b0010);
        tick(5);
        sens[3] = 1'b0;
        tick(6);
        applyStimulus(4'b1000, 6, 6);
        checkOutput("weOvf", 4'd0, 4'd0, 4'd1, 4'd15, 4'b1010);

        // Test 5: all four channels in parallel
        applyReset();
        checkOutput("resetClearsOvf", 4'd0, 4'd0, 4'd0, 4'd0, 4'b0000);
        for (int i = 0; i < 4; i++) applyStimulus(4'b1111, 6, 6);
        checkOutput("all4", 4'd4, 4'd4, 4'd4, 4'd4, 4'b0000);
        for (int i = 0; i < 6; i++) applyStimulus(4'b1111, 6, 6);
        checkOutput("all10", 4'd10, 4'd10, 4'd10, 4'd10, 4'b0000);

        // Test 6: reset mid-debounce, held sensor recounted after release
        dep = 4'b1111;
        tick(3);
        dep = 4'b0000;
        checkOutput("all7", 4'd7, 4'd7, 4'd7, 4'd7, 4'b0000);
        sens[0] = 1'b1;
        tick(2);
        applyReset();
        checkOutput("midReset", 4'd0, 4'd0, 4'd0, 4'd0, 4'b0000);
        tick(5);
        checkOutput("postResetEdge5", 4'd0, 4'd0, 4'd0, 4'd0, 4'b0000);
        tick(1);
        checkOutput("postResetEdge6", 4'd1, 4'd0, 4'd0, 4'd0, 4'b0000);
        tick(3);
        checkOutput("postResetHeld", 4'd1, 4'd0, 4'd0, 4'd0, 4'b0000);
        sens[0] = 1'b0;
        tick(2);

        if (expQ.size() != 0) begin
            testsRun++;
            failures++;
            $display("[TB] FAIL drain: got %0d pending expectations, expected 0", expQ.size());
        end
        $display("[TB] %0d tests run, %0d failed", testsRun, failures);
        $finish;
    end

endmodule
